// File: rtl/img_proc_pkg.sv
// Shared types and defaults for the image-processing threshold path.
package img_proc_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIV    = 2'd2,
    UPDATE = 2'd3
  } thr_state_e;

  // 8-bit luma sample
  typedef logic [7:0] pixel_t;

  // Default threshold and auto-threshold clamp limits
  localparam int unsigned PKG_DEFAULT_THR = 127;
  localparam int unsigned PKG_THR_MIN     = 16;
  localparam int unsigned PKG_THR_MAX     = 239;

endpackage

// File: rtl/thr_mean_div.sv
// 8-cycle restoring divider producing an 8-bit quotient (sum / count).
// The caller guarantees quotient <= 255 (dividend <= 255 * divisor).
module thr_mean_div #(
  parameter int unsigned CNT_W = 22
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W+7:0]   dividend,
  input  logic [CNT_W-1:0]   divisor,
  output logic               done,
  output logic [7:0]         quotient
);

  localparam int unsigned DW = CNT_W + 8;

  logic [DW-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0] dvs_q, dvs_d;
  logic [2:0]       bit_q, bit_d;
  logic             act_q, act_d;
  logic             done_q, done_d;
  logic [7:0]       quo_q, quo_d;
  logic [DW-1:0]    trial;

  // Load operands on start, then resolve one quotient bit per cycle, MSB first
  always_comb begin
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    bit_d  = bit_q;
    act_d  = act_q;
    quo_d  = quo_q;
    done_d = 1'b0;
    trial  = {8'b0, dvs_q} << bit_q;
    if (abort) begin
      act_d = 1'b0;
    end else if (start) begin
      rem_d = dividend;
      dvs_d = divisor;
      bit_d = 3'd7;
      quo_d = '0;
      act_d = 1'b1;
    end else if (act_q) begin
      if (rem_q >= trial) begin
        rem_d        = rem_q - trial;
        quo_d[bit_q] = 1'b1;
      end
      if (bit_q == 3'd0) begin
        act_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        bit_d = bit_q - 3'd1;
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      bit_q  <= '0;
      act_q  <= 1'b0;
      done_q <= 1'b0;
      quo_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      bit_q  <= bit_d;
      act_q  <= act_d;
      done_q <= done_d;
      quo_q  <= quo_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/img_threshold_ctrl.sv
// Adaptive binarization threshold: frame luma mean, clamped, published per frame;
// manual mode passes a programmed threshold through.
module img_threshold_ctrl
  import img_proc_pkg::*;
#(
  parameter int unsigned DEFAULT_THR = PKG_DEFAULT_THR,
  parameter int unsigned CNT_W       = 22,
  parameter int unsigned THR_MIN     = PKG_THR_MIN,
  parameter int unsigned THR_MAX     = PKG_THR_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start_i,
  input  logic       frame_end_i,
  input  logic       valid_i,
  input  logic [7:0] y_i,
  input  logic       cfg_auto_i,
  input  logic [7:0] cfg_manual_thr_i,
  output logic [7:0] thr_o,
  output logic       thr_update_o,
  output logic       busy_o
);

  localparam int unsigned SW = CNT_W + 8;

  thr_state_e       state_q, state_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pixel_t           thr_q, thr_d;
  logic             upd_q, upd_d;
  logic             pix_ok;
  logic             div_start;
  logic             div_done;
  pixel_t           div_quo;
  pixel_t           mean_clamped;

  // Divider operands are the next-state accumulators so a pixel coincident
  // with frame_end_i is included in the mean.
  thr_mean_div #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .abort    (frame_start_i),
    .dividend (sum_d),
    .divisor  (cnt_d),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Clamp the divider result into the allowed auto-threshold window
  always_comb begin
    mean_clamped = div_quo;
    if (div_quo < 8'(THR_MIN)) begin
      mean_clamped = 8'(THR_MIN);
    end else if (div_quo > 8'(THR_MAX)) begin
      mean_clamped = 8'(THR_MAX);
    end
  end

  // FSM next state, accumulation and threshold update
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    thr_d     = thr_q;
    upd_d     = 1'b0;
    div_start = 1'b0;
    pix_ok    = valid_i && (cnt_q != '1);

    if (!cfg_auto_i) begin
      thr_d = cfg_manual_thr_i;
    end

    if (frame_start_i) begin
      state_d = ACCUM;
      sum_d   = valid_i ? {{CNT_W{1'b0}}, y_i} : '0;
      cnt_d   = valid_i ? CNT_W'(1) : '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        ACCUM: begin
          if (pix_ok) begin
            sum_d = sum_q + {{CNT_W{1'b0}}, y_i};
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (frame_end_i) begin
            if (cnt_d != '0) begin
              state_d   = DIV;
              div_start = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DIV: begin
          if (div_done) begin
            state_d = UPDATE;
          end
        end
        UPDATE: begin
          state_d = IDLE;
          if (cfg_auto_i) begin
            thr_d = mean_clamped;
            upd_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, accumulator and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      thr_q   <= 8'(DEFAULT_THR);
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      upd_q   <= upd_d;
    end
  end

  assign thr_o        = thr_q;
  assign thr_update_o = upd_q;
  assign busy_o       = (state_q != IDLE);

endmodule
